// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [2:0] RES_ALUOUT    = 3'd0;
  localparam logic [2:0] RES_DATA      = 3'd1;
  localparam logic [2:0] RES_ALURESULT = 3'd2;

  // SrcA: PC, OldPC, rs1, constant zero (lui). SrcB: rs2, immediate, 4.
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;
  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

  // alt selects SUB/SRA; callers mask it for I-type so only srai sees it.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 funct7_5;
  logic                 Zero, SrcA31, SrcB31, ALUR31;
  logic                 mem_ready;
  logic                 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, mem_req;
  logic [1:0]           ALUSrcA, ALUSrcB;
  logic [2:0]           ResultSrc, ImmSrc, load_store;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal_instr;
  logic [CNT_W-1:0]     instret;

  modport master (
    input  opcode, funct3, funct7_5, Zero, SrcA31, SrcB31, ALUR31, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, mem_req,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, load_store, ALUControl,
           illegal_instr, instret
  );

  modport slave (
    output opcode, funct3, funct7_5, Zero, SrcA31, SrcB31, ALUR31, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, mem_req,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, load_store, ALUControl,
           illegal_instr, instret
  );
endinterface

// File: rtl/mc_branch_eval.sv
// Branch condition from funct3 and the ALU flags of rs1 - rs2.
module mc_branch_eval (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       src_a31,
  input  logic       src_b31,
  input  logic       alu_r31,
  output logic       taken
);
  logic sign_diff, lt_s, lt_u;

  // With differing MSBs the subtraction can overflow, so the operand MSB decides.
  assign sign_diff = src_a31 ^ src_b31;
  assign lt_s      = sign_diff ? src_a31 : alu_r31;
  assign lt_u      = sign_diff ? src_b31 : alu_r31;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt_s;
      3'b101:  taken = ~lt_s;
      3'b110:  taken = lt_u;
      3'b111:  taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with retired-instruction counter.
// Write/request strobes are forced low combinationally while rst_n is low.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUCTRL_W     = 4,
  parameter int CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             mem_done, branch_taken, retire;
  logic             pc_write, adr_src, ir_write, mem_write, reg_write, mem_req, illegal;
  logic [1:0]       alu_src_a, alu_src_b;
  logic [2:0]       result_src, imm_src;
  logic [3:0]       alu_op;

  assign mem_done = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  mc_branch_eval u_branch (
    .funct3  (bus.funct3),
    .zero    (bus.Zero),
    .src_a31 (bus.SrcA31),
    .src_b31 (bus.SrcB31),
    .alu_r31 (bus.ALUR31),
    .taken   (branch_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    illegal    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_done) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative PC+imm lands in ALUOut for branch/jal/auipc.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.opcode == OPC_JAL)   ? IMM_J :
                    (bus.opcode == OPC_AUIPC) ? IMM_U : IMM_B;
        case (bus.opcode)
          OPC_LOAD, OPC_STORE: state_next = S_MEMADR;
          OPC_OP:              state_next = S_EXECR;
          OPC_OP_IMM:          state_next = S_EXECI;
          OPC_BRANCH:          state_next = S_BRANCH;
          OPC_JAL:             state_next = S_JAL;
          OPC_JALR:            state_next = S_JALR;
          OPC_LUI, OPC_AUIPC:  state_next = S_UPPER;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (bus.opcode == OPC_STORE) ? IMM_S : IMM_I;
        state_next = (bus.opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_done) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_done) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = alu_decode(bus.funct3, bus.funct7_5);
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = alu_decode(bus.funct3, bus.funct7_5 && (bus.funct3 == 3'b101));
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
        // ALUOut holds the jalr target, so the link value is formed here.
        if (bus.opcode == OPC_JALR) begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
        end
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        pc_write   = branch_taken;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_UPPER: begin
        alu_src_a  = (bus.opcode == OPC_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign retire = (state_reg != S_FETCH) && (state_next == S_FETCH) && !illegal;

  assign bus.PCWrite       = pc_write  & rst_n;
  assign bus.AdrSrc        = adr_src;
  assign bus.IRWrite       = ir_write  & rst_n;
  assign bus.MemWrite      = mem_write & rst_n;
  assign bus.RegWrite      = reg_write & rst_n;
  assign bus.mem_req       = mem_req   & rst_n;
  assign bus.illegal_instr = illegal   & rst_n;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ResultSrc     = result_src;
  assign bus.ImmSrc        = imm_src;
  assign bus.load_store    = bus.funct3;
  assign bus.ALUControl    = ALUCTRL_W'(alu_op);
  assign bus.instret       = instret_reg;
endmodule
